// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read per cycle and
// buffers responses in a 2-entry skid buffer. Optional macro: FETCH_MISALIGN_CHECK_EN.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_FAULT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_epoch;
  logic        r_inflight;
  logic        r_inflight_epoch;
  logic [31:0] r_inflight_pc;
  logic [1:0]  r_count;
  logic [31:0] r_buf_pc    [2];
  logic [31:0] r_buf_instr [2];

  logic        w_redirect;
  logic        w_misalign;
  logic [31:0] w_target;
  logic        w_deq;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occ;
  logic [1:0]  w_count_after;
  logic        w_wr_idx;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;
  assign w_misalign  = (redirect_pc[1:0] != 2'b00);
  assign w_target    = redirect_pc;
  assign fetch_fault = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault <= 1'b0;
    else if (w_redirect && w_misalign) r_fault <= 1'b1;
  end
`else
  assign w_misalign  = 1'b0;
  assign w_target    = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_fault = 1'b0;
`endif

  // Handshake: an instruction transfers to decode on a rising edge where
  // if_valid && id_ready; if_instr/if_pc hold steady while if_valid && !id_ready.
  assign w_redirect    = redirect_valid && (r_state != S_FAULT);
  assign w_deq         = (r_count != 2'd0) && id_ready;
  assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_issue       = (r_state == S_RUN) && (w_occ < 3'd2);
  assign w_push        = r_inflight && (r_inflight_epoch == r_epoch) && !w_redirect;
  assign w_count_after = r_count - {1'b0, w_deq};
  assign w_wr_idx      = w_count_after[0];

  assign imem_addr  = r_pc;
  assign imem_rd_en = w_issue;
  assign if_valid   = (r_count != 2'd0);
  assign if_pc      = r_buf_pc[0];
  assign if_instr   = r_buf_instr[0];
  assign dbg_state  = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      S_FLUSH: w_state_nxt = S_RUN;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_BOOT;
    endcase
    if (w_redirect) w_state_nxt = w_misalign ? S_FAULT : S_FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_state_nxt;
  end

  // The epoch tags each read so a response issued before a redirect is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc             <= RESET_PC;
      r_epoch          <= 1'b0;
      r_inflight       <= 1'b0;
      r_inflight_epoch <= 1'b0;
      r_inflight_pc    <= '0;
    end else begin
      r_inflight       <= w_issue;
      r_inflight_epoch <= r_epoch;
      r_inflight_pc    <= r_pc;
      if (w_redirect) begin
        r_pc    <= w_target;
        r_epoch <= ~r_epoch;
      end else if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count        <= 2'd0;
      r_buf_pc[0]    <= '0;
      r_buf_pc[1]    <= '0;
      r_buf_instr[0] <= '0;
      r_buf_instr[1] <= '0;
    end else if (w_redirect) begin
      r_count <= 2'd0;
    end else begin
      if (w_deq) begin
        r_buf_pc[0]    <= r_buf_pc[1];
        r_buf_instr[0] <= r_buf_instr[1];
      end
      // A push lands after the shift, into the first free slot.
      if (w_push) begin
        r_buf_pc[w_wr_idx]    <= r_inflight_pc;
        r_buf_instr[w_wr_idx] <= imem_rdata;
      end
      r_count <= w_count_after + {1'b0, w_push};
    end
  end

endmodule
